// File: rtl/cnn_layer_accel_weight_loader.sv
// Weight-table feeder: accepts a job, pulses job_accept, then streams
// (num_kernels+1)*C_KERNEL_SIZE words into the table, one write per handshake.
module cnn_layer_accel_weight_loader #(
  parameter int unsigned C_KERNEL_SIZE      = 9,
  parameter int unsigned C_CLG2_MAX_KERNELS = 6,
  parameter int unsigned C_DATA_WIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          job_start,
  input  logic [C_CLG2_MAX_KERNELS-1:0] num_kernels,
  input  logic                          abort,
  input  logic                          wht_in_valid,
  output logic                          wht_in_ready,
  input  logic [C_DATA_WIDTH-1:0]       wht_in_data,
  output logic                          config_mode,
  output logic                          job_accept,
  output logic                          wht_config_wren,
  output logic [C_DATA_WIDTH-1:0]       wht_config_data,
  output logic                          load_done,
  output logic                          busy
);

  localparam int unsigned WCW = (C_KERNEL_SIZE > 1) ? $clog2(C_KERNEL_SIZE) : 1;
  localparam int unsigned KW  = C_CLG2_MAX_KERNELS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [WCW-1:0]          word_cnt_q, word_cnt_d;
  logic [KW-1:0]           kern_cnt_q, kern_cnt_d;
  logic [KW-1:0]           nk_q, nk_d;
  logic                    config_mode_q, config_mode_d;
  logic                    job_accept_q, job_accept_d;
  logic                    wren_q, wren_d;
  logic [C_DATA_WIDTH-1:0] data_q, data_d;
  logic                    load_done_q, load_done_d;
  logic                    busy_q, busy_d;

  logic handshake;
  logic word_last;
  logic last_word;

  // Abort masks ready in its own cycle so no word is consumed by a cancelled job.
  assign wht_in_ready = (state_q == ST_LOAD) && !abort;
  assign handshake    = wht_in_valid && wht_in_ready;
  assign word_last    = (word_cnt_q == WCW'(C_KERNEL_SIZE - 1));
  assign last_word    = word_last && (kern_cnt_q == nk_q);

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    kern_cnt_d = kern_cnt_q;
    nk_d       = nk_q;
    data_d     = data_q;
    wren_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (job_start && !abort) begin
          state_d    = ST_ACCEPT;
          nk_d       = num_kernels;
          word_cnt_d = '0;
          kern_cnt_d = '0;
        end
      end
      ST_ACCEPT: state_d = ST_LOAD;
      ST_LOAD: begin
        if (handshake) begin
          wren_d = 1'b1;
          data_d = wht_in_data;
          // Final compare happens before any increment, so kern_cnt never wraps.
          if (last_word) begin
            state_d    = ST_DONE;
            word_cnt_d = '0;
            kern_cnt_d = '0;
          end else if (word_last) begin
            word_cnt_d = '0;
            kern_cnt_d = kern_cnt_q + KW'(1);
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      word_cnt_d = '0;
      kern_cnt_d = '0;
    end

    // Status outputs are registered from the next state so they line up with it.
    job_accept_d  = (state_d == ST_ACCEPT);
    load_done_d   = (state_d == ST_DONE);
    config_mode_d = (state_d != ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      word_cnt_q    <= '0;
      kern_cnt_q    <= '0;
      nk_q          <= '0;
      config_mode_q <= 1'b0;
      job_accept_q  <= 1'b0;
      wren_q        <= 1'b0;
      data_q        <= '0;
      load_done_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      kern_cnt_q    <= kern_cnt_d;
      nk_q          <= nk_d;
      config_mode_q <= config_mode_d;
      job_accept_q  <= job_accept_d;
      wren_q        <= wren_d;
      data_q        <= data_d;
      load_done_q   <= load_done_d;
      busy_q        <= busy_d;
    end
  end

  assign config_mode     = config_mode_q;
  assign job_accept      = job_accept_q;
  assign wht_config_wren = wren_q;
  assign wht_config_data = data_q;
  assign load_done       = load_done_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_loader.sv
// Bench for cnn_layer_accel_weight_loader: job table driven through a
// cycle-level driver/monitor, plus hand sequences for reset and idle abort.
module tb_cnn_layer_accel_weight_loader;

  logic        clk;
  logic        rst;
  logic        job_start;
  logic [5:0]  num_kernels;
  logic        abort;
  logic        wht_in_valid;
  logic        wht_in_ready;
  logic [15:0] wht_in_data;
  logic        config_mode;
  logic        job_accept;
  logic        wht_config_wren;
  logic [15:0] wht_config_data;
  logic        load_done;
  logic        busy;

  int checks = 0;
  int failures = 0;

  cnn_layer_accel_weight_loader #(
    .C_KERNEL_SIZE      (9),
    .C_CLG2_MAX_KERNELS (6),
    .C_DATA_WIDTH       (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .job_start       (job_start),
    .num_kernels     (num_kernels),
    .abort           (abort),
    .wht_in_valid    (wht_in_valid),
    .wht_in_ready    (wht_in_ready),
    .wht_in_data     (wht_in_data),
    .config_mode     (config_mode),
    .job_accept      (job_accept),
    .wht_config_wren (wht_config_wren),
    .wht_config_data (wht_config_data),
    .load_done       (load_done),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int nk;
    int bubble;
    int abort_at;
    int spur_at;
    int exp_wren;
    int exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int row, input vec_t v);
    int sent, wr, dones, accepts, cm_drops, data_err;
    int acc_cyc, rdy_cyc, done_cyc, abort_cyc, end_cyc;
    int ld_wren, post_cm, post_rdy, post_busy;
    bit aborted, spur_done, ended;
    logic [15:0] base;
    sent = 0; wr = 0; dones = 0; accepts = 0; cm_drops = 0; data_err = 0;
    acc_cyc = -1; rdy_cyc = -1; done_cyc = -1; abort_cyc = -1; end_cyc = -1;
    ld_wren = -1; post_cm = -1; post_rdy = -1; post_busy = -1;
    aborted = 0; spur_done = 0; ended = 0;
    base = 16'(row * 1000);

    job_start    = 1'b1;
    num_kernels  = 6'(v.nk);
    wht_in_valid = 1'b0;
    abort        = 1'b0;

    for (int cyc = 1; cyc < 2000; cyc++) begin
      tick();
      if (wht_config_wren) begin
        if (wht_config_data !== 16'(base + 16'(wr))) data_err++;
        wr++;
      end
      if (job_accept) begin
        accepts++;
        if (acc_cyc < 0) acc_cyc = cyc;
      end
      if (wht_in_ready && rdy_cyc < 0) rdy_cyc = cyc;
      if (load_done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          ld_wren  = wht_config_wren ? wr : -1;
          end_cyc  = cyc + 1;
        end
      end
      if (acc_cyc >= 0 && (done_cyc < 0 || cyc <= done_cyc) &&
          !(aborted && cyc > abort_cyc) && !config_mode)
        cm_drops++;
      if (cyc == end_cyc) begin
        post_cm   = config_mode;
        post_rdy  = wht_in_ready;
        post_busy = busy;
      end
      if (end_cyc > 0 && cyc == end_cyc + 3) begin
        ended = 1;
        break;
      end

      job_start    = 1'b0;
      abort        = 1'b0;
      num_kernels  = 6'(~v.nk);
      wht_in_valid = ($urandom_range(0, 99) >= v.bubble);
      wht_in_data  = 16'(base + 16'(sent));
      if (v.spur_at > 0 && sent == v.spur_at && !spur_done) begin
        job_start   = 1'b1;
        num_kernels = 6'd5;
        spur_done   = 1;
      end
      if (v.abort_at > 0 && sent == v.abort_at && !aborted) begin
        abort        = 1'b1;
        wht_in_valid = 1'b1;
        aborted      = 1;
        abort_cyc    = cyc;
        end_cyc      = cyc + 1;
      end
      #1;
      if (wht_in_valid && wht_in_ready) sent++;
    end

    wht_in_valid = 1'b0;
    job_start    = 1'b0;
    abort        = 1'b0;
    chk($sformatf("row%0d_finished", row), int'(ended), 1);
    chk($sformatf("row%0d_wren_count", row), wr, v.exp_wren);
    chk($sformatf("row%0d_words_consumed", row), sent, v.exp_wren);
    chk($sformatf("row%0d_data_errors", row), data_err, 0);
    chk($sformatf("row%0d_load_done_count", row), dones, v.exp_done);
    chk($sformatf("row%0d_job_accept_count", row), accepts, 1);
    chk($sformatf("row%0d_accept_cycle", row), acc_cyc, 1);
    chk($sformatf("row%0d_first_ready_cycle", row), rdy_cyc, 2);
    chk($sformatf("row%0d_config_mode_drops", row), cm_drops, 0);
    chk($sformatf("row%0d_post_config_mode", row), post_cm, 0);
    chk($sformatf("row%0d_post_ready", row), post_rdy, 0);
    chk($sformatf("row%0d_post_busy", row), post_busy, 0);
    if (v.exp_done == 1)
      chk($sformatf("row%0d_done_with_last_wren", row), ld_wren, v.exp_wren);
  endtask

  initial begin
    vecs[0] = '{nk: 0,  bubble: 0,  abort_at: 0,  spur_at: 0,  exp_wren: 9,   exp_done: 1};
    vecs[1] = '{nk: 3,  bubble: 50, abort_at: 0,  spur_at: 0,  exp_wren: 36,  exp_done: 1};
    vecs[2] = '{nk: 2,  bubble: 0,  abort_at: 0,  spur_at: 10, exp_wren: 27,  exp_done: 1};
    vecs[3] = '{nk: 2,  bubble: 0,  abort_at: 13, spur_at: 0,  exp_wren: 13,  exp_done: 0};
    vecs[4] = '{nk: 0,  bubble: 0,  abort_at: 0,  spur_at: 0,  exp_wren: 9,   exp_done: 1};
    vecs[5] = '{nk: 63, bubble: 0,  abort_at: 0,  spur_at: 0,  exp_wren: 576, exp_done: 1};
    vecs[6] = '{nk: 1,  bubble: 30, abort_at: 0,  spur_at: 0,  exp_wren: 18,  exp_done: 1};

    rst = 1'b1; job_start = 1'b0; num_kernels = '0; abort = 1'b0;
    wht_in_valid = 1'b0; wht_in_data = '0;
    repeat (3) tick();
    chk("reset_config_mode", int'(config_mode), 0);
    chk("reset_job_accept", int'(job_accept), 0);
    chk("reset_wren", int'(wht_config_wren), 0);
    chk("reset_data", int'(wht_config_data), 0);
    chk("reset_load_done", int'(load_done), 0);
    chk("reset_ready", int'(wht_in_ready), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_job(i, vecs[i]);

    // abort and job_start together in IDLE: abort wins
    abort = 1'b1; job_start = 1'b1; num_kernels = 6'd1;
    tick();
    chk("idle_abort_busy", int'(busy), 0);
    chk("idle_abort_accept", int'(job_accept), 0);
    abort = 1'b0; job_start = 1'b0;
    tick();
    chk("idle_abort_busy_later", int'(busy), 0);
    chk("idle_abort_accept_later", int'(job_accept), 0);

    // reset mid-load
    job_start = 1'b1; num_kernels = 6'd2; wht_in_valid = 1'b1; wht_in_data = 16'h5A5A;
    tick();
    job_start = 1'b0;
    repeat (8) tick();
    chk("midload_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    tick();
    chk("midrst_wren", int'(wht_config_wren), 0);
    chk("midrst_data", int'(wht_config_data), 0);
    chk("midrst_config_mode", int'(config_mode), 0);
    chk("midrst_ready", int'(wht_in_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_load_done", int'(load_done), 0);
    rst = 1'b0;
    tick();
    tick();
    chk("postrst_wren", int'(wht_config_wren), 0);
    chk("postrst_busy", int'(busy), 0);
    wht_in_valid = 1'b0;
    run_job(7, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
